histeq_master_fsm: RTL

- Top-level sequencer for the histogram equalizer core.
- Drives the core's phase-start inputs (start_histogram, start_cdf, start_divider) and input_mem_read_finished.
- Consumes the core's completion outputs (histogram_computation_done, cdf_done) plus a divider completion flag.
- Runs one image job per start request, with a per-phase watchdog, a sticky error and an abort path. Sits between the system host/testbench and histogram_equalizer_core.

---
 rtl/histeq_master_fsm.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/histeq_master_fsm.sv
// histeq_master_fsm
// Top-level sequencer for the histogram equalizer core. Runs one image job
// per start request: HIST -> CDF -> DIV -> DONE, with a per-phase watchdog,
// a sticky error state and an abort path back to IDLE.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   start, abort                 host job request / synchronous abort
//   histogram_input_mem_raddr0   core's input-memory read address (monitored)
//   histogram_computation_done,
//   cdf_done, divider_done       phase completion flags (level-sampled)
//   start_histogram, start_cdf,
//   start_divider                phase-start outputs to the core
//   input_mem_read_finished      set once the last input word was addressed
//   busy, job_done               job in progress / one-cycle completion pulse
//   error, error_phase           sticky watchdog error, 1=HIST 2=CDF 3=DIV
//
// Optional feature (macro HISTEQ_PHASE_PERF_EN): adds hist_cycles,
// cdf_cycles and div_cycles, the saturating length of each phase in the
// last normally completed job.
module histeq_master_fsm #(
    parameter int LAST_INPUT_ADDR = 4095,
    parameter int TIMEOUT_CYCLES  = 200000,
    parameter int CNT_W           = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] histogram_input_mem_raddr0,
    input  logic        histogram_computation_done,
    input  logic        cdf_done,
    input  logic        divider_done,
    output logic        start_histogram,
    output logic        start_cdf,
    output logic        start_divider,
    output logic        input_mem_read_finished,
    output logic        busy,
    output logic        job_done,
    output logic        error,
    output logic [1:0]  error_phase
`ifdef HISTEQ_PHASE_PERF_EN
    ,
    output logic [31:0] hist_cycles,
    output logic [31:0] cdf_cycles,
    output logic [31:0] div_cycles
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_HIST, S_CDF, S_DIV, S_DONE, S_ERR} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]      LAST_ADDR = 16'(LAST_INPUT_ADDR);

    state_t           state, state_n;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
    logic             sh_n, sc_n, sd_n, imrf_n, busy_n, jd_n, err_n;
    logic [1:0]       eph_n;
    logic             timeout;

    // Fires on the last allowed cycle of a phase; a done in the same cycle wins
    // because the done checks come first below.
    assign timeout = (TIMEOUT_CYCLES != 0) && (wd_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                   <= S_IDLE;
            wd_cnt                  <= '0;
            start_histogram         <= 1'b0;
            start_cdf               <= 1'b0;
            start_divider           <= 1'b0;
            input_mem_read_finished <= 1'b0;
            busy                    <= 1'b0;
            job_done                <= 1'b0;
            error                   <= 1'b0;
            error_phase             <= 2'd0;
        end else begin
            state                   <= state_n;
            wd_cnt                  <= wd_cnt_n;
            start_histogram         <= sh_n;
            start_cdf               <= sc_n;
            start_divider           <= sd_n;
            input_mem_read_finished <= imrf_n;
            busy                    <= busy_n;
            job_done                <= jd_n;
            error                   <= err_n;
            error_phase             <= eph_n;
        end
    end

    always_comb begin
        state_n  = state;
        sh_n     = start_histogram;
        sc_n     = start_cdf;
        sd_n     = start_divider;
        imrf_n   = input_mem_read_finished;
        busy_n   = busy;
        jd_n     = 1'b0;
        err_n    = error;
        eph_n    = error_phase;
        wd_cnt_n = '0;

        if (abort) begin
            state_n = S_IDLE;
            sh_n    = 1'b0;
            sc_n    = 1'b0;
            sd_n    = 1'b0;
            imrf_n  = 1'b0;
            busy_n  = 1'b0;
            err_n   = 1'b0;
            eph_n   = 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_HIST;
                        sh_n    = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
                S_HIST: begin
                    wd_cnt_n = wd_cnt + 1'b1;
                    if (histogram_computation_done) begin
                        state_n  = S_CDF;
                        sh_n     = 1'b0;
                        sc_n     = 1'b1;
                        imrf_n   = 1'b0;
                        wd_cnt_n = '0;
                    end else if (timeout) begin
                        state_n = S_ERR;
                        sh_n    = 1'b0;
                        imrf_n  = 1'b0;
                        busy_n  = 1'b0;
                        err_n   = 1'b1;
                        eph_n   = 2'd1;
                    end else if (histogram_input_mem_raddr0 == LAST_ADDR) begin
                        imrf_n = 1'b1;
                    end
                end
                S_CDF: begin
                    wd_cnt_n = wd_cnt + 1'b1;
                    if (cdf_done) begin
                        state_n  = S_DIV;
                        sc_n     = 1'b0;
                        sd_n     = 1'b1;
                        wd_cnt_n = '0;
                    end else if (timeout) begin
                        state_n = S_ERR;
                        sc_n    = 1'b0;
                        busy_n  = 1'b0;
                        err_n   = 1'b1;
                        eph_n   = 2'd2;
                    end
                end
                S_DIV: begin
                    wd_cnt_n = wd_cnt + 1'b1;
                    if (divider_done) begin
                        state_n  = S_DONE;
                        sd_n     = 1'b0;
                        busy_n   = 1'b0;
                        jd_n     = 1'b1;
                        wd_cnt_n = '0;
                    end else if (timeout) begin
                        state_n = S_ERR;
                        sd_n    = 1'b0;
                        busy_n  = 1'b0;
                        err_n   = 1'b1;
                        eph_n   = 2'd3;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                S_ERR:   state_n = S_ERR;
                default: state_n = S_IDLE;
            endcase
        end
    end

`ifdef HISTEQ_PHASE_PERF_EN
    logic [31:0] perf_cnt, perf_inc;

    assign perf_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

    // perf_cnt restarts on every state change, so at a phase's exit edge
    // perf_inc equals the number of cycles that phase's start_* was high.
    // Only the normal successor state records, so aborts and timeouts don't.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_cnt    <= '0;
            hist_cycles <= '0;
            cdf_cycles  <= '0;
            div_cycles  <= '0;
        end else begin
            if (state_n != state)
                perf_cnt <= '0;
            else if (state == S_HIST || state == S_CDF || state == S_DIV)
                perf_cnt <= perf_inc;
            if (state == S_HIST && state_n == S_CDF)  hist_cycles <= perf_inc;
            if (state == S_CDF  && state_n == S_DIV)  cdf_cycles  <= perf_inc;
            if (state == S_DIV  && state_n == S_DONE) div_cycles  <= perf_inc;
        end
    end
`endif

endmodule
